step_gen_bus: RTL and testbench
===============================

# step_gen_bus

Memory-mapped step/direction pulse generator that acts as a responder on the CPU's native memory bus (mem_valid/mem_ready handshake). The top level's address decoder drives its `enable`, and firmware programs a step count, a half-period and a direction. The block then emits that many step pulses on the step pin (gp[0]) with a stable direction level (gp[1]) and drives the driver-enable pin (gp[2]). It returns status on the shared read-data bus.

## Interface
- `CNT_WIDTH`, 16: width of the half-period timer and the HALF_PERIOD register.
- `STEP_WIDTH`, 32: width of the STEPS register (remaining-step counter).
- `clk_in` input 1: system clock (25 MHz); all logic on rising edge.
- `reset_in` input 1: synchronous, active-high reset.
- `enable` input 1: decoded select from top-level address map; qualifies `mem_valid`.
- `mem_valid` input 1: CPU request valid.
- `addr_in` input 2: word offset (byte address bits [3:2]).
- `mem_wstrb` input 4: byte write strobes; 0 = read.
- `data_in` input 32: CPU write data.
- `data_out` output 32: read data; 0 whenever `ready` is low, so the bus can be OR-shared.
- `ready` output 1: one-cycle transaction acknowledge.
- `step_out` output 1: step pulse to driver.
- `dir_out` output 1: direction level.
- `drv_en_n_out` output 1: driver enable, active low.
- `busy_out` output 1: high while the FSM is not IDLE.

## Operation
- Register map (word offset):
  - 0 CTRL: [0] run, [1] dir, [2] drv_en. R/W.
  - 1 HALF_PERIOD: [CNT_WIDTH-1:0]. R/W.
  - 2 STEPS: [STEP_WIDTH-1:0]. R/W; reads return the live remaining count.
  - 3 STATUS: [0] busy (RO), [1] done (sticky; write 1 clears).
  - Unused bits read 0.
- Access starts when `enable & mem_valid & !ready`.
- Writes apply each byte lane i where `mem_wstrb[i]`=1. Reads occur when `mem_wstrb`=0.
- Writes to HALF_PERIOD or STEPS while busy are ignored (registers unchanged, `ready` still given).
- Writes to CTRL while busy behave as follows:
  - run and drv_en update immediately.
  - dir is stored, but `dir_out` only follows CTRL.dir while the FSM is in IDLE.
- `drv_en_n_out` = !CTRL.drv_en, combinational from the register.
- Effective half-period H = max(HALF_PERIOD, 1).
- FSM has three states: IDLE, HIGH, LOW. `timer` counts down.
  - IDLE:
    - `dir_out` <= CTRL.dir.
    - If run & drv_en & STEPS≠0: go to HIGH, `step_out`<=1, timer<=H-1.
  - HIGH:
    - If timer≠0: timer decrements.
    - At timer=0: go to LOW, `step_out`<=0, timer<=H-1.
  - LOW:
    - If timer≠0: timer decrements.
    - At timer=0: STEPS<=STEPS-1. Then:
      - If STEPS-1=0: go to IDLE, set done, clear CTRL.run.
      - Else if run & drv_en: go to HIGH, `step_out`<=1, timer<=H-1.
      - Else: go to IDLE, with the remaining count kept.
- Clearing run or drv_en mid-step never truncates a pulse. The current HIGH/LOW cycle completes, then the FSM stops.
- A done-clear write and a done-set on the same edge resolve with set winning.
- STEPS never wraps below 0.

## Timing
- Reset values:
  - All registers are 0.
  - FSM is IDLE and timer is 0.
  - `step_out`=0, `dir_out`=0, `drv_en_n_out`=1, `busy_out`=0, `ready`=0, `data_out`=0.
- Bus latency:
  - `ready` rises exactly one clock after the request is first seen and stays high exactly one cycle.
  - `data_out` is valid in that same cycle.
  - The write commits on the edge that raises `ready`.
- `ready` is never high two consecutive cycles. A new request is accepted on the cycle after `ready` falls.
- First step: `step_out` rises on the edge following the one that raises `ready` for the enabling write.
- Pulse shape: high for H clocks, low for H clocks. Period is 2H clocks and back-to-back steps have no gap.
- `busy_out` is high from the HIGH entry edge through the edge that returns the FSM to IDLE.
- `dir_out` is stable throughout a run. It changes at least one full cycle before the next rising `step_out`.
- Reset mid-run: on the reset edge, `step_out` goes to 0 and all state returns to reset values.

## Test plan
- Reset, then read all four offsets -> each returns 0 with `ready` high for exactly 1 cycle, 1 clock after request; `drv_en_n_out`=1.
- Write HALF_PERIOD with wstrb=4'b0001, data 0xAABB_CC05 -> readback 0x0000_0005. Then write with wstrb=4'b0011 -> readback 0x0000_CC05.
- Write HALF_PERIOD=3, STEPS=4, CTRL=0b111 -> exactly 4 pulses, each 3 high / 3 low, `dir_out`=1 throughout.
  - Afterwards: STATUS reads 0b10, CTRL reads 0b110, `busy_out` is 0.
  - Writing STATUS=0b10 clears it to 0.
- HALF_PERIOD=0, STEPS=2, run -> 2 pulses of 1 clock high / 1 clock low. Period is 2 clocks.
- Start STEPS=10, H=5; clear run during the 3rd pulse's HIGH phase -> that pulse completes full 5/5, then IDLE.
  - STEPS reads 7 and done stays 0.
  - A write of STEPS=1 while busy is ignored (readback is the live count).
- Assert `reset_in` mid-HIGH with STEPS=6 -> next cycle `step_out`=0, `busy_out`=0, and all registers read 0.

Source files
------------

// File: rtl/step_gen_bus_if.sv
// rtl/step_gen_bus_if.sv - CPU native memory bus (mem_valid/ready) seen by the step generator
interface step_gen_bus_if;
    logic        enable;
    logic        mem_valid;
    logic [1:0]  addr_in;
    logic [3:0]  mem_wstrb;
    logic [31:0] data_in;
    logic [31:0] data_out;
    logic        ready;

    modport master (
        output enable, mem_valid, addr_in, mem_wstrb, data_in,
        input  data_out, ready
    );

    modport slave (
        input  enable, mem_valid, addr_in, mem_wstrb, data_in,
        output data_out, ready
    );
endinterface

// File: rtl/step_gen_bus.sv
// rtl/step_gen_bus.sv - memory-mapped step/direction pulse generator
module step_gen_bus #(
    parameter int CNT_WIDTH  = 16,
    parameter int STEP_WIDTH = 32
) (
    input  logic               clk_in,
    input  logic               reset_in,
    step_gen_bus_if.slave      bus,
    output logic               step_out,
    output logic               dir_out,
    output logic               drv_en_n_out,
    output logic               busy_out
);
    typedef enum logic [1:0] {S_IDLE, S_HIGH, S_LOW} state_t;

    localparam logic [CNT_WIDTH-1:0]  CNT_ONE  = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [STEP_WIDTH-1:0] STEP_ONE = {{(STEP_WIDTH-1){1'b0}}, 1'b1};

    state_t                 state_q, state_d;
    logic [CNT_WIDTH-1:0]   timer_q, timer_d;
    logic [CNT_WIDTH-1:0]   half_q, half_d;
    logic [STEP_WIDTH-1:0]  steps_q, steps_d;
    logic                   run_q, run_d, dir_q, dir_d, drv_q, drv_d, done_q, done_d;
    logic                   step_q, step_d, dir_out_q, dir_out_d;
    logic                   ready_q, ready_d;
    logic [31:0]            rdata_q, rdata_d;

    logic                   req, wr_en, rd_en, busy;
    logic [CNT_WIDTH-1:0]   h_eff;
    logic [31:0]            wmerge;

    function automatic logic [31:0] lane_merge(input logic [31:0] old_v,
                                               input logic [31:0] new_v,
                                               input logic [3:0]  strb);
        logic [31:0] r;
        r = old_v;
        for (int i = 0; i < 4; i++)
            if (strb[i]) r[8*i +: 8] = new_v[8*i +: 8];
        return r;
    endfunction

    always_comb begin
        req   = bus.enable & bus.mem_valid & ~ready_q;
        wr_en = req & (|bus.mem_wstrb);
        rd_en = req & ~(|bus.mem_wstrb);
        busy  = (state_q != S_IDLE);
        h_eff = (half_q == '0) ? CNT_ONE : half_q;

        wmerge    = '0;
        ready_d   = req;
        rdata_d   = '0;
        run_d     = run_q;
        dir_d     = dir_q;
        drv_d     = drv_q;
        done_d    = done_q;
        half_d    = half_q;
        steps_d   = steps_q;
        state_d   = state_q;
        timer_d   = timer_q;
        step_d    = step_q;
        dir_out_d = dir_out_q;

        // Read data is registered and forced to zero outside the ack cycle so the bus can be OR-shared.
        if (rd_en) begin
            case (bus.addr_in)
                2'd0:    rdata_d = {29'd0, drv_q, dir_q, run_q};
                2'd1:    rdata_d = 32'(half_q);
                2'd2:    rdata_d = 32'(steps_q);
                default: rdata_d = {30'd0, done_q, busy};
            endcase
        end

        if (wr_en) begin
            case (bus.addr_in)
                2'd0: begin
                    wmerge = lane_merge({29'd0, drv_q, dir_q, run_q}, bus.data_in, bus.mem_wstrb);
                    run_d  = wmerge[0];
                    dir_d  = wmerge[1];
                    drv_d  = wmerge[2];
                end
                2'd1: begin
                    wmerge = lane_merge(32'(half_q), bus.data_in, bus.mem_wstrb);
                    if (!busy) half_d = wmerge[CNT_WIDTH-1:0];
                end
                2'd2: begin
                    wmerge = lane_merge(32'(steps_q), bus.data_in, bus.mem_wstrb);
                    if (!busy) steps_d = wmerge[STEP_WIDTH-1:0];
                end
                default: begin
                    if (bus.mem_wstrb[0] && bus.data_in[1]) done_d = 1'b0;
                end
            endcase
        end

        // FSM assignments follow the bus writes so a same-edge done set / run clear wins.
        case (state_q)
            S_IDLE: begin
                dir_out_d = dir_d;
                if (run_q && drv_q && steps_q != '0) begin
                    state_d = S_HIGH;
                    step_d  = 1'b1;
                    timer_d = h_eff - CNT_ONE;
                end
            end
            S_HIGH: begin
                if (timer_q != '0) begin
                    timer_d = timer_q - CNT_ONE;
                end else begin
                    state_d = S_LOW;
                    step_d  = 1'b0;
                    timer_d = h_eff - CNT_ONE;
                end
            end
            S_LOW: begin
                if (timer_q != '0) begin
                    timer_d = timer_q - CNT_ONE;
                end else begin
                    steps_d = steps_q - STEP_ONE;
                    if (steps_q == STEP_ONE) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                        run_d   = 1'b0;
                    end else if (run_q && drv_q) begin
                        state_d = S_HIGH;
                        step_d  = 1'b1;
                        timer_d = h_eff - CNT_ONE;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            state_q   <= S_IDLE;
            timer_q   <= '0;
            half_q    <= '0;
            steps_q   <= '0;
            run_q     <= 1'b0;
            dir_q     <= 1'b0;
            drv_q     <= 1'b0;
            done_q    <= 1'b0;
            step_q    <= 1'b0;
            dir_out_q <= 1'b0;
            ready_q   <= 1'b0;
            rdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            half_q    <= half_d;
            steps_q   <= steps_d;
            run_q     <= run_d;
            dir_q     <= dir_d;
            drv_q     <= drv_d;
            done_q    <= done_d;
            step_q    <= step_d;
            dir_out_q <= dir_out_d;
            ready_q   <= ready_d;
            rdata_q   <= rdata_d;
        end
    end

    assign bus.ready    = ready_q;
    assign bus.data_out = rdata_q;
    assign step_out     = step_q;
    assign dir_out      = dir_out_q;
    assign drv_en_n_out = ~drv_q;
    assign busy_out     = (state_q != S_IDLE);
endmodule

// File: tb/tb_step_gen_bus.sv
// tb/tb_step_gen_bus.sv - self-checking bench for step_gen_bus
module tb_step_gen_bus;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    step_gen_bus_if bus();
    logic step_o, dir_o, drv_n_o, busy_o;

    step_gen_bus #(.CNT_WIDTH(16), .STEP_WIDTH(32)) dut (
        .clk_in(clk), .reset_in(rst), .bus(bus),
        .step_out(step_o), .dir_out(dir_o), .drv_en_n_out(drv_n_o), .busy_out(busy_o)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] lanes(input logic [31:0] o, input logic [31:0] n, input logic [3:0] s);
        logic [31:0] r;
        r = o;
        for (int i = 0; i < 4; i++) if (s[i]) r[8*i +: 8] = n[8*i +: 8];
        return r;
    endfunction

    // Reference: a pulse is a run of 2H cycles indexed by m_pos; step is high for the first H.
    logic        m_started = 1'b0;
    logic        m_ready, m_run, m_dir, m_drv, m_done, m_busy, m_dir_out;
    logic [31:0] m_rdata, m_steps, m_tmp;
    logic [15:0] m_half;
    int          m_pos;
    logic        p_run, p_drv, p_busy, m_req;
    logic [31:0] p_steps;

    function automatic int h_of(input logic [15:0] hp);
        return (hp == 16'd0) ? 1 : int'(hp);
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_started = 1'b1;
            {m_ready, m_run, m_dir, m_drv, m_done, m_busy, m_dir_out} = '0;
            m_rdata = '0; m_steps = '0; m_half = '0; m_pos = 0;
        end else if (m_started) begin
            m_req   = bus.enable & bus.mem_valid & ~m_ready;
            p_run   = m_run; p_drv = m_drv; p_busy = m_busy; p_steps = m_steps;
            m_rdata = '0;
            if (m_req && bus.mem_wstrb == 4'd0) begin
                case (bus.addr_in)
                    2'd0: m_rdata = {29'd0, m_drv, m_dir, m_run};
                    2'd1: m_rdata = {16'd0, m_half};
                    2'd2: m_rdata = m_steps;
                    default: m_rdata = {30'd0, m_done, m_busy};
                endcase
            end
            if (m_req && bus.mem_wstrb != 4'd0) begin
                case (bus.addr_in)
                    2'd0: begin
                        m_tmp = lanes({29'd0, m_drv, m_dir, m_run}, bus.data_in, bus.mem_wstrb);
                        m_run = m_tmp[0]; m_dir = m_tmp[1]; m_drv = m_tmp[2];
                    end
                    2'd1: if (!p_busy) begin
                        m_tmp  = lanes({16'd0, m_half}, bus.data_in, bus.mem_wstrb);
                        m_half = m_tmp[15:0];
                    end
                    2'd2: if (!p_busy) m_steps = lanes(m_steps, bus.data_in, bus.mem_wstrb);
                    default: if (bus.mem_wstrb[0] && bus.data_in[1]) m_done = 1'b0;
                endcase
            end
            m_ready = m_req;
            if (!p_busy) begin
                m_dir_out = m_dir;
                if (p_run && p_drv && p_steps != 0) begin
                    m_busy = 1'b1;
                    m_pos  = 0;
                end
            end else if (m_pos == 2 * h_of(m_half) - 1) begin
                m_steps = p_steps - 1;
                if (m_steps == 0) begin
                    m_done = 1'b1; m_run = 1'b0; m_busy = 1'b0;
                end else if (p_run && p_drv) begin
                    m_pos = 0;
                end else begin
                    m_busy = 1'b0;
                end
            end else begin
                m_pos++;
            end
        end
    end

    always @(negedge clk) begin
        if (m_started) begin
            check("ready",    {31'd0, bus.ready}, {31'd0, m_ready});
            check("data_out", bus.data_out, m_rdata);
            check("step_out", {31'd0, step_o}, {31'd0, (m_busy && m_pos < h_of(m_half))});
            check("dir_out",  {31'd0, dir_o}, {31'd0, m_dir_out});
            check("drv_en_n", {31'd0, drv_n_o}, {31'd0, ~m_drv});
            check("busy_out", {31'd0, busy_o}, {31'd0, m_busy});
        end
    end

    // Pulse-shape monitor
    logic mon_prev = 1'b0;
    int   mon_rises, hi_len, lo_len, hi_min, hi_max, lo_min, lo_max;

    task automatic clr_mon();
        mon_rises = 0; hi_len = 0; lo_len = 0;
        hi_min = 9999; hi_max = 0; lo_min = 9999; lo_max = 0;
    endtask

    always @(negedge clk) begin
        if (step_o && !mon_prev) begin
            mon_rises++;
            if (mon_rises > 1) begin
                if (lo_len < lo_min) lo_min = lo_len;
                if (lo_len > lo_max) lo_max = lo_len;
            end
            hi_len = 1;
        end else if (step_o) begin
            hi_len++;
        end else if (mon_prev) begin
            if (hi_len < hi_min) hi_min = hi_len;
            if (hi_len > hi_max) hi_max = hi_len;
            lo_len = 1;
        end else begin
            lo_len++;
        end
        mon_prev = step_o;
    end

    task automatic xfer(input logic [1:0] a, input logic [3:0] s, input logic [31:0] d, output logic [31:0] r);
        int n;
        n = 0;
        @(negedge clk);
        bus.enable = 1'b1; bus.mem_valid = 1'b1; bus.addr_in = a; bus.mem_wstrb = s; bus.data_in = d;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.ready && n < 8);
        check("ready_latency", n, 1);
        r = bus.data_out;
        bus.enable = 1'b0; bus.mem_valid = 1'b0; bus.mem_wstrb = 4'd0;
    endtask

    task automatic wr(input logic [1:0] a, input logic [3:0] s, input logic [31:0] d);
        logic [31:0] r;
        xfer(a, s, d, r);
    endtask

    task automatic rd_chk(input string name, input logic [1:0] a, input logic [31:0] exp);
        logic [31:0] r;
        xfer(a, 4'd0, 32'd0, r);
        check(name, r, exp);
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        @(negedge clk);
        while (busy_o && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("idle_timeout", {31'd0, busy_o}, 32'd0);
    endtask

    task automatic wait_rises(input int target, input int budget);
        int n;
        n = 0;
        while (mon_rises < target && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("rise_timeout", mon_rises, target);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rdat;
        logic [3:0]  s;
        logic        d;
        bus.enable = 1'b0; bus.mem_valid = 1'b0; bus.addr_in = 2'd0;
        bus.mem_wstrb = 4'd0; bus.data_in = 32'd0;
        clr_mon();
        repeat (2) @(negedge clk);
        rst = 1'b0;

        for (int a = 0; a < 4; a++) rd_chk("reset_read", 2'(a), 32'd0);
        check("reset_drv_en_n", {31'd0, drv_n_o}, 32'd1);

        wr(2'd1, 4'b0001, 32'hAABB_CC05);
        rd_chk("half_lane0", 2'd1, 32'h0000_0005);
        wr(2'd1, 4'b0011, 32'hAABB_CC05);
        rd_chk("half_lane01", 2'd1, 32'h0000_CC05);

        wr(2'd1, 4'hF, 32'd3);
        wr(2'd2, 4'hF, 32'd4);
        clr_mon();
        wr(2'd0, 4'hF, 32'd7);
        wait_idle(100);
        check("h3_pulses", mon_rises, 4);
        check("h3_hi_min", hi_min, 3);
        check("h3_hi_max", hi_max, 3);
        check("h3_lo_min", lo_min, 3);
        check("h3_lo_max", lo_max, 3);
        check("h3_dir", {31'd0, dir_o}, 32'd1);
        rd_chk("h3_status", 2'd3, 32'h2);
        rd_chk("h3_ctrl", 2'd0, 32'h6);
        wr(2'd3, 4'hF, 32'h2);
        rd_chk("done_clear", 2'd3, 32'h0);

        wr(2'd1, 4'hF, 32'd0);
        wr(2'd2, 4'hF, 32'd2);
        clr_mon();
        wr(2'd0, 4'hF, 32'd5);
        wait_idle(50);
        check("h0_pulses", mon_rises, 2);
        check("h0_hi", hi_max, 1);
        check("h0_lo", lo_max, 1);
        wr(2'd3, 4'hF, 32'h2);

        wr(2'd1, 4'hF, 32'd5);
        wr(2'd2, 4'hF, 32'd10);
        clr_mon();
        wr(2'd0, 4'hF, 32'd7);
        wait_rises(2, 60);
        wr(2'd2, 4'hF, 32'd1);
        wait_rises(3, 60);
        wr(2'd0, 4'hF, 32'd6);
        wait_idle(200);
        check("stop_pulses", mon_rises, 3);
        check("stop_hi_min", hi_min, 5);
        check("stop_hi_max", hi_max, 5);
        check("stop_lo_min", lo_min, 5);
        rd_chk("stop_steps", 2'd2, 32'd7);
        rd_chk("stop_status", 2'd3, 32'd0);

        wr(2'd1, 4'hF, 32'd2);
        wr(2'd2, 4'hF, 32'd6);
        clr_mon();
        wr(2'd0, 4'hF, 32'd7);
        wait_rises(1, 20);
        rst = 1'b1;
        @(negedge clk);
        check("rst_step", {31'd0, step_o}, 32'd0);
        check("rst_busy", {31'd0, busy_o}, 32'd0);
        check("rst_drv_n", {31'd0, drv_n_o}, 32'd1);
        rst = 1'b0;
        for (int a = 0; a < 4; a++) rd_chk("rst_mid_read", 2'(a), 32'd0);

        for (int it = 0; it < 15; it++) begin
            s = 4'($urandom_range(1, 15));
            d = 1'($urandom_range(0, 1));
            wr(2'd1, s, {24'd0, 8'($urandom_range(0, 3))});
            wr(2'd2, 4'hF, 32'($urandom_range(1, 4)));
            @(negedge clk);
            bus.enable = 1'b0; bus.mem_valid = 1'b1;
            bus.addr_in = 2'($urandom_range(0, 3)); bus.mem_wstrb = 4'($urandom_range(0, 15));
            bus.data_in = $urandom;
            @(negedge clk);
            bus.mem_valid = 1'b0; bus.mem_wstrb = 4'd0;
            wr(2'd0, 4'hF, {29'd0, ($urandom_range(0, 7) != 0), d, 1'b1});
            for (int k = 0; k < int'($urandom_range(0, 3)); k++) begin
                case ($urandom_range(0, 3))
                    0: xfer(2'($urandom_range(0, 3)), 4'd0, 32'd0, rdat);
                    1: wr(2'd1, 4'hF, 32'($urandom_range(0, 3)));
                    2: wr(2'd2, 4'hF, 32'($urandom_range(1, 4)));
                    default: begin
                        if ($urandom_range(0, 2) == 0) wr(2'd0, 4'hF, {29'd0, 1'b1, d, 1'b0});
                        else repeat ($urandom_range(1, 5)) @(negedge clk);
                    end
                endcase
            end
            wait_idle(300);
            wr(2'd3, 4'b0001, 32'h2);
        end

        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
